// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request feeding a registered prefetch queue.
// Optional redirect counter output enabled by `define INSTR_FETCH_REDIRECT_CNT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef INSTR_FETCH_REDIRECT_CNT_EN
    output logic [31:0] instr_pc_plus_4,
    output logic [31:0] redirect_cnt
`else
    output logic [31:0] instr_pc_plus_4
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0]   DEPTH   = (PW+1)'(QDEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   q_pc   [QDEPTH];
    logic [31:0]   q_data [QDEPTH];

    logic accept;
    logic push;
    logic pop;

    // Redirect suppresses the request so a dropped fetch never reaches memory.
    assign imem_req = ~reset & ~redirect_valid
                    & (state_q == S_REQ) & (count_q < DEPTH);
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req & imem_ready;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & ~stall & ~redirect_valid;

    assign instr           = instr_valid ? q_data[rd_ptr_q] : '0;
    assign instr_pc        = instr_valid ? q_pc[rd_ptr_q] : '0;
    assign instr_pc_plus_4 = instr_valid ? q_pc[rd_ptr_q] + 32'd4 : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            unique case (state_q)
                S_REQ:   state_d = S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        state_d    = S_WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible below count_q.
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            q_pc[wr_ptr_q]   <= req_pc_q;
            q_data[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef INSTR_FETCH_REDIRECT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt <= '0;
        end else if (redirect_valid) begin
            redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_instr_fetch;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus_4;
`ifdef INSTR_FETCH_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
`ifdef INSTR_FETCH_REDIRECT_CNT_EN
        .instr_pc_plus_4 (instr_pc_plus_4),
        .redirect_cnt    (redirect_cnt)
`else
        .instr_pc_plus_4 (instr_pc_plus_4)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    logic        d_reset = 1'b1;
    logic        d_redir = 1'b0;
    logic [31:0] d_rpc = '0;
    logic        d_stall = 1'b0;
    logic        d_ready = 1'b1;
    logic        d_spur = 1'b0;
    logic        saw_acc = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    resp_t mem_q[$];
    ent_t  mq[$];
    logic  m_out = 1'b0;
    logic  m_drop = 1'b0;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_req_pc = RPC;
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name, input int n, input int lim);
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL %s: waited %0d cycles, limit %0d", name, n, lim);
        end
    endtask

    task automatic compare_and_advance();
        logic exp_req;
        logic ev;
        logic acc;
        exp_req = !reset && !redirect_valid && !m_out && (mq.size() < QD);
        ev = (mq.size() > 0);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, ev);
        chk("instr", instr, ev ? mq[0].data : 32'h0);
        chk("instr_pc", instr_pc, ev ? mq[0].pc : 32'h0);
        chk("instr_pc_plus_4", instr_pc_plus_4, ev ? mq[0].pc + 32'd4 : 32'h0);
        if (instr_valid && !stall && !redirect_valid && !reset) begin
            got_pc.push_back(instr_pc);
            got_instr.push_back(instr);
        end
        saw_acc = imem_req && imem_ready;
        if (saw_acc)
            mem_q.push_back('{due: cyc + lat, data: mem_word(imem_addr)});
        acc = exp_req && imem_ready;
        if (reset) begin
            m_out = 1'b0;
            m_drop = 1'b0;
            mq.delete();
            m_pc = RPC;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out) begin
                if (imem_rvalid) begin
                    m_out = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (ev && !stall) void'(mq.pop_front());
            if (imem_rvalid && m_out) begin
                if (!m_drop) mq.push_back('{pc: m_req_pc, data: imem_rdata});
                m_out = 1'b0;
                m_drop = 1'b0;
            end
            if (acc) begin
                m_out = 1'b1;
                m_req_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        reset = d_reset;
        redirect_valid = d_redir;
        redirect_pc = d_rpc;
        stall = d_stall;
        imem_ready = d_ready;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = d_spur;
            imem_rdata = 32'hDEAD_BEEF;
        end
        #3;
        compare_and_advance();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        d_reset = 1'b1;
        d_redir = 1'b0;
        repeat (n) cycle();
        d_reset = 1'b0;
    endtask

    task automatic wait_acc(input string name);
        int n;
        n = 0;
        cycle();
        while (!saw_acc && n < 30) begin
            cycle();
            n++;
        end
        timeout(name, n, 30);
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int n;
        n = 0;
        cycle();
        while (!imem_req && n < 30) begin
            cycle();
            n++;
        end
        timeout(name, n, 30);
        chk(name, imem_addr, addr);
    endtask

    task automatic wait_got(input int target);
        int n;
        n = 0;
        while (got_pc.size() < target && n < 60) begin
            cycle();
            n++;
        end
        timeout("wait_got", n, 60);
    endtask

    logic [31:0] stall_vec = 32'b0110_0011_1000_0100_1110_0000_1100_1010;
    logic [31:0] ready_vec = 32'b1101_1110_0111_1011_0101_1111_1010_1111;

    initial begin
        int n0;
        int n1;
        logic [31:0] last;

        do_reset(2);
        chk("rst_imem_req", imem_req, 32'h0);
        chk("rst_instr_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus_4", instr_pc_plus_4, 32'h0);

        // In-order fetch stream from the reset address.
        wait_got(4);
        chk("seq_pc0", got_pc[0], 32'h0);
        chk("seq_pc1", got_pc[1], 32'h4);
        chk("seq_pc2", got_pc[2], 32'h8);
        chk("seq_pc3", got_pc[3], 32'hC);
        chk("seq_in0", got_instr[0], 32'hA000_0000);
        chk("seq_in1", got_instr[1], 32'hA000_0004);
        chk("seq_in2", got_instr[2], 32'hA000_0008);
        chk("seq_in3", got_instr[3], 32'hA000_000C);

        // Back-pressure fills the queue and stops requests.
        d_stall = 1'b1;
        repeat (10) cycle();
        chk("full_no_req", imem_req, 32'h0);
        chk("full_valid", instr_valid, 32'h1);
        n0 = got_pc.size();
        last = got_pc[n0-1];
        d_stall = 1'b0;
        wait_got(n0 + 4);
        chk("stall_first", got_pc[n0], 32'h10);
        for (int k = 0; k < 4; k++)
            chk("stall_noloss", got_pc[n0+k], last + 32'(4 * (k + 1)));

        // Redirect while waiting: response drained, aligned target fetched.
        lat = 3;
        wait_acc("acc_to_1");
        d_redir = 1'b1;
        d_rpc = 32'h0000_0103;
        cycle();
        d_redir = 1'b0;
        n1 = got_pc.size();
        wait_req("redir_wait_addr", 32'h0000_0100);
        wait_got(n1 + 1);
        chk("redir_first_pc", got_pc[n1], 32'h100);
        chk("redir_first_in", got_instr[n1], 32'hA000_0100);

        // Second redirect during drain only moves the fetch address.
        wait_acc("acc_to_2");
        d_redir = 1'b1;
        d_rpc = 32'h0000_0103;
        cycle();
        d_rpc = 32'h0000_040E;
        cycle();
        d_redir = 1'b0;
        wait_req("drain_redir_addr", 32'h0000_040C);
        lat = 1;

        // Redirect coincident with response and pop.
        do_reset(4);
        d_stall = 1'b1;
        repeat (3) cycle();
        d_redir = 1'b1;
        d_rpc = 32'h0000_0300;
        d_stall = 1'b0;
        cycle();
        chk("coinc_pre_valid", instr_valid, 32'h1);
        d_redir = 1'b0;
        d_stall = 1'b1;
        cycle();
        chk("coinc_empty", instr_valid, 32'h0);
        chk("coinc_req", imem_req, 32'h1);
        chk("coinc_addr", imem_addr, 32'h0000_0300);

        // Address wrap at the top of the address space.
        do_reset(2);
        d_redir = 1'b1;
        d_rpc = 32'hFFFF_FFFC;
        cycle();
        d_redir = 1'b0;
        repeat (3) cycle();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", instr_pc_plus_4, 32'h0);
        chk("wrap_in", instr, 32'h5FFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Stray response with nothing outstanding is ignored.
        do_reset(2);
        d_ready = 1'b0;
        d_spur = 1'b1;
        repeat (2) cycle();
        d_spur = 1'b0;
        cycle();
        chk("spur_ignored", instr_valid, 32'h0);
        d_ready = 1'b1;
        d_stall = 1'b0;

        // Mixed stall/ready pattern with a redirect in the middle.
        lat = 2;
        for (int i = 0; i < 32; i++) begin
            d_stall = stall_vec[i];
            d_ready = ready_vec[i];
            d_redir = (i == 17);
            d_rpc = 32'h0000_0A02;
            cycle();
        end
        d_redir = 1'b0;
        d_stall = 1'b0;
        d_ready = 1'b1;
        repeat (6) cycle();
        lat = 1;

`ifdef INSTR_FETCH_REDIRECT_CNT_EN
        do_reset(4);
        d_rpc = 32'h0000_0200;
        d_redir = 1'b1;
        repeat (5) cycle();
        d_redir = 1'b0;
        cycle();
        chk("redirect_cnt5", redirect_cnt, 32'd5);
        do_reset(2);
        chk("redirect_cnt0", redirect_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
